// File: rtl/serial_logic_unit4.sv
// Bit-serial bitwise logic unit: latches two operands and an op code, evaluates one
// bit per clock LSB first through a single gate slice, then publishes Result/Zero with a done pulse.
module serial_logic_unit4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       Op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             bit_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic             r;
  logic [WIDTH-1:0] res_nx;

  function automatic logic gate(input logic [1:0] op, input logic a, input logic b);
    logic g;
    case (op)
      2'b00:   g = a & b;
      2'b01:   g = a | b;
      2'b10:   g = a ^ b;
      default: g = ~(a & b);
    endcase
    return g;
  endfunction

  assign r       = gate(op_q, a_sh[0], b_sh[0]);
  assign res_nx  = {r, res_sh[WIDTH-1:1]};
  assign bit_out = busy & r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      Result <= '0;
      Zero   <= 1'b1;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      op_q   <= 2'b00;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            op_q  <= Op;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nx;
          cnt    <= cnt + 1'b1;
          // Result/Zero only move on the completing edge, so partial values never show
          if (cnt == CNT_W'(WIDTH - 1)) begin
            Result <= res_nx;
            Zero   <= (res_nx == '0);
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
